ysyx_24100006_trap_seq: RTL and testbench

//  Sequences the single-write-port CSR register file for trap entry (ecall/exception/interrupt) and mret.

---
 rtl/ysyx_24100006_trap_seq_pkg.sv | 27 ++
 rtl/ysyx_24100006_mstatus_upd.sv | 28 ++
 rtl/ysyx_24100006_trap_seq.sv | 127 ++++++++++++
 tb/tb_ysyx_24100006_trap_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100006_trap_seq_pkg.sv
// Shared constants for the trap/mret CSR sequencer.
//   - Machine-mode CSR addresses touched by the sequencer.
//   - mstatus bit positions (MIE, MPIE, MPP).
//   - Sequencer state encoding.
package ysyx_24100006_trap_seq_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_EPC,
    S_T_CAUSE,
    S_T_STAT,
    S_T_VEC,
    S_R_STAT,
    S_R_VEC
  } state_t;

endpackage

// File: rtl/ysyx_24100006_mstatus_upd.sv
// Combinational mstatus rewrite for trap entry and mret.
//   mstatus     in   current mstatus value
//   is_mret     in   1 = mret update, 0 = trap-entry update
//   mstatus_new out  updated mstatus; bits other than MIE/MPIE/MPP pass through
module ysyx_24100006_mstatus_upd
  import ysyx_24100006_trap_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] mstatus,
  input  logic                  is_mret,
  output logic [DATA_WIDTH-1:0] mstatus_new
);

  always_comb begin
    mstatus_new = mstatus;
    if (is_mret) begin
      mstatus_new[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
      mstatus_new[MSTATUS_MPIE] = 1'b1;
    end else begin
      mstatus_new[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
      mstatus_new[MSTATUS_MIE]  = 1'b0;
    end
    // Only M-mode exists, so MPP is always M in both directions.
    mstatus_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

endmodule

// File: rtl/ysyx_24100006_trap_seq.sv
// Trap-entry / mret sequencer in front of the single-write-port CSR file.
// Serialises mepc, mcause and mstatus writes, then redirects fetch. While
// idle it passes the core's CSR-instruction traffic straight through.
//   trap_valid/cause/epc, mret_valid, req_ready : request from commit
//   csrw_valid/addr/data, csrw_ready            : CSR-instruction write
//   core_raddr, core_rdata                      : ID-stage CSR read
//   csr_wen/waddr/wdata, csr_raddr, csr_rdata   : CSR file port
//   redirect_valid, redirect_pc                 : PC redirect to IFU
//   busy                                        : commit stall
module ysyx_24100006_trap_seq
  import ysyx_24100006_trap_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trap_valid,
  input  logic [DATA_WIDTH-1:0] trap_cause,
  input  logic [DATA_WIDTH-1:0] trap_epc,
  input  logic                  mret_valid,
  output logic                  req_ready,
  input  logic                  csrw_valid,
  input  logic [ADDR_WIDTH-1:0] csrw_addr,
  input  logic [DATA_WIDTH-1:0] csrw_data,
  output logic                  csrw_ready,
  input  logic [ADDR_WIDTH-1:0] core_raddr,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  csr_wen,
  output logic [ADDR_WIDTH-1:0] csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic [ADDR_WIDTH-1:0] csr_raddr,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  busy
);

  state_t                state;
  logic [DATA_WIDTH-1:0] epc_q;
  logic [DATA_WIDTH-1:0] cause_q;
  logic [DATA_WIDTH-1:0] mstatus_new;
  logic                  is_mret;

  assign is_mret = (state == S_R_STAT);

  ysyx_24100006_mstatus_upd #(.DATA_WIDTH(DATA_WIDTH)) u_mstatus_upd (
    .mstatus     (csr_rdata),
    .is_mret     (is_mret),
    .mstatus_new (mstatus_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Trap has priority; a simultaneous mret is dropped.
          if (trap_valid) begin
            epc_q   <= trap_epc;
            cause_q <= trap_cause;
            state   <= S_T_EPC;
          end else if (mret_valid) begin
            state <= S_R_STAT;
          end
        end
        S_T_EPC:   state <= S_T_CAUSE;
        S_T_CAUSE: state <= S_T_STAT;
        S_T_STAT:  state <= S_T_VEC;
        S_T_VEC:   state <= S_IDLE;
        S_R_STAT:  state <= S_R_VEC;
        S_R_VEC:   state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign req_ready  = (state == S_IDLE);
  assign csrw_ready = (state == S_IDLE);
  assign core_rdata = csr_rdata;

  always_comb begin
    csr_wen        = 1'b0;
    csr_waddr      = csrw_addr;
    csr_wdata      = csrw_data;
    csr_raddr      = core_raddr;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      S_IDLE: csr_wen = csrw_valid;
      S_T_EPC: begin
        csr_wen   = 1'b1;
        csr_waddr = ADDR_WIDTH'(CSR_MEPC);
        csr_wdata = epc_q;
      end
      S_T_CAUSE: begin
        csr_wen   = 1'b1;
        csr_waddr = ADDR_WIDTH'(CSR_MCAUSE);
        csr_wdata = cause_q;
      end
      S_T_STAT, S_R_STAT: begin
        // Read-modify-write in one cycle against the combinational read port.
        csr_raddr = ADDR_WIDTH'(CSR_MSTATUS);
        csr_wen   = 1'b1;
        csr_waddr = ADDR_WIDTH'(CSR_MSTATUS);
        csr_wdata = mstatus_new;
      end
      S_T_VEC: begin
        // Direct mode only: mode bits of mtvec are ignored.
        csr_raddr      = ADDR_WIDTH'(CSR_MTVEC);
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[DATA_WIDTH-1:2], 2'b00};
      end
      S_R_VEC: begin
        csr_raddr      = ADDR_WIDTH'(CSR_MEPC);
        redirect_valid = 1'b1;
        redirect_pc    = csr_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24100006_trap_seq.sv
module tb_ysyx_24100006_trap_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_epc;
  logic        mret_valid;
  logic        req_ready;
  logic        csrw_valid;
  logic [11:0] csrw_addr;
  logic [31:0] csrw_data;
  logic        csrw_ready;
  logic [11:0] core_raddr;
  logic [31:0] core_rdata;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_24100006_trap_seq dut (
    .clk(clk), .rst(rst),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_epc(trap_epc),
    .mret_valid(mret_valid), .req_ready(req_ready),
    .csrw_valid(csrw_valid), .csrw_addr(csrw_addr), .csrw_data(csrw_data),
    .csrw_ready(csrw_ready),
    .core_raddr(core_raddr), .core_rdata(core_rdata),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  // CSR file the DUT drives: synchronous write, combinational read.
  logic        mem_clr;
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else if (csr_wen) begin
      mem[csr_waddr] <= csr_wdata;
    end
  end
  assign csr_rdata = mem[csr_raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted request becomes a list of per-cycle expected port actions
  // derived from the architectural trap/mret rules on a reference CSR copy.
  typedef struct {
    bit          wen;
    logic [11:0] addr;
    logic [31:0] data;
    bit          rv;
    logic [31:0] pc;
  } act_t;

  act_t        plan[$];
  logic [31:0] ref_csr [0:4095];

  always @(negedge clk) begin
    act_t a;
    logic [31:0] ms;
    if (mem_clr) for (int i = 0; i < 4096; i++) ref_csr[i] = '0;
    if (rst) plan.delete();
    if (plan.size() == 0) begin
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
      chk("idle_csrw_ready", {31'd0, csrw_ready}, 32'd1);
      chk("idle_redirect", {31'd0, redirect_valid}, 32'd0);
      chk("idle_wen", {31'd0, csr_wen}, {31'd0, csrw_valid});
      chk("idle_rdata", core_rdata, ref_csr[core_raddr]);
      if (csrw_valid) begin
        chk("idle_waddr", {20'd0, csr_waddr}, {20'd0, csrw_addr});
        chk("idle_wdata", csr_wdata, csrw_data);
        if (!mem_clr) ref_csr[csrw_addr] = csrw_data;
      end
      if (!rst && trap_valid) begin
        ms = ref_csr[12'h300];
        plan.push_back('{1'b1, 12'h341, trap_epc, 1'b0, 32'd0});
        plan.push_back('{1'b1, 12'h342, trap_cause, 1'b0, 32'd0});
        plan.push_back('{1'b1, 12'h300,
                         (ms & ~32'h1888) | 32'h1800 | (ms[3] ? 32'h80 : 32'h0),
                         1'b0, 32'd0});
        plan.push_back('{1'b0, 12'h000, 32'd0, 1'b1, ref_csr[12'h305] & ~32'h3});
      end else if (!rst && mret_valid) begin
        ms = ref_csr[12'h300];
        plan.push_back('{1'b1, 12'h300,
                         (ms & ~32'h1888) | 32'h1880 | (ms[7] ? 32'h8 : 32'h0),
                         1'b0, 32'd0});
        plan.push_back('{1'b0, 12'h000, 32'd0, 1'b1, ref_csr[12'h341]});
      end
    end else begin
      a = plan.pop_front();
      chk("seq_busy", {31'd0, busy}, 32'd1);
      chk("seq_req_ready", {31'd0, req_ready}, 32'd0);
      chk("seq_csrw_ready", {31'd0, csrw_ready}, 32'd0);
      chk("seq_wen", {31'd0, csr_wen}, {31'd0, a.wen});
      chk("seq_redirect", {31'd0, redirect_valid}, {31'd0, a.rv});
      if (a.wen) begin
        chk("seq_waddr", {20'd0, csr_waddr}, {20'd0, a.addr});
        chk("seq_wdata", csr_wdata, a.data);
        ref_csr[a.addr] = a.data;
      end
      if (a.rv) chk("seq_redirect_pc", redirect_pc, a.pc);
    end
  end

  // ---------------- directed stimulus + literal expectations ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nrv;
    rst = 1'b1; mem_clr = 1'b1;
    trap_valid = 0; trap_cause = 0; trap_epc = 0; mret_valid = 0;
    csrw_valid = 0; csrw_addr = 0; csrw_data = 0; core_raddr = 0;
    tick(); tick();
    mem_clr = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    tick();
    rst = 1'b0;

    // 1. idle passthrough
    tick();
    csrw_valid = 1; csrw_addr = 12'h305; csrw_data = 32'h80000100; core_raddr = 12'h305;
    #1 chk("t1_wen_same_cycle", {31'd0, csr_wen}, 32'd1);
    tick();
    csrw_addr = 12'h300; csrw_data = 32'h8;
    #1 chk("t1_rdata_next", core_rdata, 32'h80000100);
    tick();
    csrw_valid = 0;

    // 2. trap entry
    trap_valid = 1; trap_epc = 32'h80000010; trap_cause = 32'd11;
    tick();
    trap_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk("t2_busy", {31'd0, busy}, {31'd0, k <= 4});
      chk("t2_redirect", {31'd0, redirect_valid}, {31'd0, k == 4});
      if (k == 4) chk("t2_pc", redirect_pc, 32'h80000100);
      tick();
    end
    chk("t2_mepc", mem[12'h341], 32'h80000010);
    chk("t2_mcause", mem[12'h342], 32'd11);
    chk("t2_mstatus", mem[12'h300], 32'h1880);

    // 3. mret
    mret_valid = 1;
    tick();
    mret_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("t3_busy", {31'd0, busy}, {31'd0, k <= 2});
      chk("t3_redirect", {31'd0, redirect_valid}, {31'd0, k == 2});
      if (k == 2) chk("t3_pc", redirect_pc, 32'h80000010);
      tick();
    end
    chk("t3_mstatus", mem[12'h300], 32'h1888);

    // 4. trap and mret together: trap only
    trap_valid = 1; mret_valid = 1; trap_epc = 32'h80000044; trap_cause = 32'd2;
    tick();
    trap_valid = 0; mret_valid = 0;
    nrv = 0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (redirect_valid) begin
        nrv++;
        chk("t4_pc", redirect_pc, 32'h80000100);
      end
      tick();
    end
    chk("t4_redirects", nrv, 32'd1);
    chk("t4_mepc", mem[12'h341], 32'h80000044);
    chk("t4_mstatus", mem[12'h300], 32'h1880);

    // 5. back-pressure on CSR-instruction write
    trap_valid = 1; trap_epc = 32'h80000050; trap_cause = 32'h8000000B;
    tick();
    trap_valid = 0;
    tick();
    csrw_valid = 1; csrw_addr = 12'h340; csrw_data = 32'hDEADBEEF;
    for (int k = 2; k <= 5; k++) begin
      #1;
      chk("t5_csrw_ready", {31'd0, csrw_ready}, {31'd0, k == 5});
      if (k == 4) begin
        chk("t5_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("t5_mscratch_not_yet", mem[12'h340], 32'd0);
      end
      if (k == 5) chk("t5_wen", {31'd0, csr_wen}, 32'd1);
      tick();
    end
    csrw_valid = 0;
    chk("t5_mscratch", mem[12'h340], 32'hDEADBEEF);
    chk("t5_mcause", mem[12'h342], 32'h8000000B);

    // 6. reset in T_STAT
    csrw_valid = 1; csrw_addr = 12'h300; csrw_data = 32'h8;
    tick();
    csrw_valid = 0;
    trap_valid = 1; trap_epc = 32'h80000060; trap_cause = 32'd5;
    tick();
    trap_valid = 0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_redirect", {31'd0, redirect_valid}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t6_no_redirect", {31'd0, redirect_valid}, 32'd0);
      tick();
    end
    chk("t6_mstatus", mem[12'h300], 32'h8);
    chk("t6_mepc", mem[12'h341], 32'h80000060);
    chk("t6_mcause", mem[12'h342], 32'd5);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
